ifu_redirect_ctrl: RTL and testbench
====================================

Name: ifu_redirect_ctrl

Overview:
- Front-end redirect arbiter and sequencer that sits directly upstream of pcGen.
- Collects redirect requests from IF0, IF1, IF2 and EXU and selects one per cycle by age priority (exu > if2 > if1 > if0).
- Drives pcGen's one-hot redirect valids, target PC and stall, and generates per-stage flushes.
- Owns the post-reset boot wait and latches redirects that arrive while the front end is stalled, replaying them on stall release.

Parameters:
- MXLEN, 64, PC width; must match `MXLEN.
- BOOT_WAIT, 4, cycles o_stall is held after reset release; legal range 1..255.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_stall  in  1  back-pressure from the icache or decode.
- i_if0_redir_valid / i_if1_redir_valid / i_if2_redir_valid / i_exu_redir_valid  in  1 each  redirect request per source.
- i_if0_redir_pc / i_if1_redir_pc / i_if2_redir_pc / i_exu_redir_pc  in  MXLEN each  redirect target per source.
- o_pcIf0_RedirectArb_valid / o_pcIf1_RedirectArb_valid / o_pcIf2_RedirectArb_valid / o_pcExu_RedirectArb_valid  out  1 each  one-hot grant to pcGen.
- o_redir_pc  out  MXLEN  granted target; drives all four pcGen npc inputs.
- o_stall  out  1  stall to pcGen.
- o_flush_if0 / o_flush_if1 / o_flush_if2  out  1 each  kill the stage's current contents.
- o_busy  out  1  state != RUN, or a redirect is pending.
- o_perf_exu_cnt / o_perf_fe_cnt  out  32 each  redirect counters (see Optional Feature).

Behaviour:
- Reset (async assert): state=BOOT, boot counter=0, pending cleared, counters cleared.
  - While i_rst is high: all grants 0, all flushes 0, o_redir_pc=0, o_stall=1, o_busy=1.
- State BOOT:
  - o_stall=1, grants 0, all redirect inputs ignored (not latched).
  - Counter increments each cycle; BOOT -> RUN on the edge where counter==BOOT_WAIT-1.
  - o_stall therefore stays high for exactly BOOT_WAIT cycles after reset deassertion.
- State RUN, i_stall=0 (issue cycle):
  - Candidates = live valids plus the pending entry (if set).
  - Winner = highest priority: exu > if2 > if1 > if0. If pending and live are the same source, the live request wins.
  - Exactly one grant is asserted, combinationally in the same cycle; o_redir_pc = winner's target.
  - Pending is cleared.
- Flushes, same cycle as the grant:
  - exu -> flush if0, if1, if2.
  - if2 -> flush if0, if1.
  - if1 -> flush if0.
  - if0 -> no flush.
- State RUN, i_stall=1:
  - o_stall=1; grants 0 (pcGen ignores redirects under stall anyway); flushes 0.
  - The highest-priority live request is latched into pending (source id plus PC).
  - It overwrites existing pending only if its priority is >= the pending one; lower priority is dropped.
  - Pending replays in the first cycle with i_stall=0, arbitrated against live requests as above.
- Reset mid-operation: pending and counters are discarded; re-enter BOOT.
- No valids and no pending in an issue cycle: all grants 0, o_redir_pc=0, so pcGen takes its sequential PC.
- Latency: live redirect to grant is 0 cycles; stalled redirect to grant is 0 cycles after stall release.

Optional Feature:
- Macro REDIRECT_PERF_EN.
- Defined:
  - o_perf_exu_cnt increments on each EXU grant.
  - o_perf_fe_cnt increments on each IF0/IF1/IF2 grant.
  - Counts are taken at grant, not at latch; counters wrap modulo 2^32; cleared by reset.
- Undefined: both ports tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset release, BOOT_WAIT=4, no requests -> o_stall=1 for exactly 4 cycles, then 0; o_busy falls with o_stall; all grants 0 throughout.
- RUN, same cycle if0 (0x1000), if2 (0x2000), exu (0x3000) -> only o_pcExu_RedirectArb_valid=1, o_redir_pc=0x3000, flush_if0/1/2=1; next cycle idle, all 0.
- RUN, i_stall=1 for 3 cycles, if1 0x4000 in cycle 1 and if2 0x5000 in cycle 2 -> no grants during stall; on release, if2 granted with 0x5000, flush_if0/1=1; if1 request is gone.
- Stall with pending exu 0x6000; on release cycle live if2 0x7000 -> exu wins, o_redir_pc=0x6000, all three flushes set.
- i_rst asserted mid-stall with pending exu -> outputs reset immediately (o_stall=1, grants 0); after release, BOOT repeats and no stale redirect appears.
- REDIRECT_PERF_EN defined: 3 exu grants plus 5 if-stage grants -> o_perf_exu_cnt=3, o_perf_fe_cnt=5. Undefined: both ports 0.

Source files
------------

// File: rtl/ifu_redirect_ctrl.sv
// Front-end redirect arbiter ahead of pcGen: boot wait, age-priority grant, stall-time latching and replay.
// Optional REDIRECT_PERF_EN adds EXU / front-end grant counters (ports read 0 when undefined).
//   state   | meaning
//   ST_BOOT | post-reset wait, o_stall held, redirects ignored
//   ST_RUN  | arbitrate live + pending redirects, latch under i_stall
module ifu_redirect_ctrl #(
  parameter int MXLEN     = 64,
  parameter int BOOT_WAIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_if0_redir_valid,
  input  logic             i_if1_redir_valid,
  input  logic             i_if2_redir_valid,
  input  logic             i_exu_redir_valid,
  input  logic [MXLEN-1:0] i_if0_redir_pc,
  input  logic [MXLEN-1:0] i_if1_redir_pc,
  input  logic [MXLEN-1:0] i_if2_redir_pc,
  input  logic [MXLEN-1:0] i_exu_redir_pc,
  output logic             o_pcIf0_RedirectArb_valid,
  output logic             o_pcIf1_RedirectArb_valid,
  output logic             o_pcIf2_RedirectArb_valid,
  output logic             o_pcExu_RedirectArb_valid,
  output logic [MXLEN-1:0] o_redir_pc,
  output logic             o_stall,
  output logic             o_flush_if0,
  output logic             o_flush_if1,
  output logic             o_flush_if2,
  output logic             o_busy,
  output logic [31:0]      o_perf_exu_cnt,
  output logic [31:0]      o_perf_fe_cnt
);

  typedef enum logic {ST_BOOT, ST_RUN} state_e;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_WAIT - 1);

  state_e           state_q, state_d;
  logic [7:0]       boot_cnt_q, boot_cnt_d;
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_src_q, pend_src_d;
  logic [MXLEN-1:0] pend_pc_q, pend_pc_d;

  // Source index doubles as priority: 0=if0, 1=if1, 2=if2, 3=exu.
  logic [3:0]       live_v, cand_v, grant;
  logic [MXLEN-1:0] live_pc [4];
  logic [MXLEN-1:0] cand_pc [4];
  logic [1:0]       live_src, cand_src;
  logic [2:0]       flush;
  logic [MXLEN-1:0] redir_pc;
  logic             stall;

  function automatic logic [1:0] top_src(input logic [3:0] v);
    if (v[3]) return 2'd3;
    if (v[2]) return 2'd2;
    if (v[1]) return 2'd1;
    return 2'd0;
  endfunction

  assign live_v     = {i_exu_redir_valid, i_if2_redir_valid, i_if1_redir_valid, i_if0_redir_valid};
  assign live_pc[0] = i_if0_redir_pc;
  assign live_pc[1] = i_if1_redir_pc;
  assign live_pc[2] = i_if2_redir_pc;
  assign live_pc[3] = i_exu_redir_pc;

  // A live request from the same source as the pending one supersedes it.
  always_comb begin
    cand_v  = live_v;
    cand_pc = live_pc;
    if (pend_vld_q && !live_v[pend_src_q]) begin
      cand_v[pend_src_q]  = 1'b1;
      cand_pc[pend_src_q] = pend_pc_q;
    end
    live_src = top_src(live_v);
    cand_src = top_src(cand_v);
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pend_vld_d = pend_vld_q;
    pend_src_d = pend_src_q;
    pend_pc_d  = pend_pc_q;
    grant      = 4'b0;
    redir_pc   = '0;
    flush      = 3'b0;
    stall      = 1'b1;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 8'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = 8'd0;
        end
      end
      ST_RUN: begin
        if (i_stall) begin
          if (|live_v && (!pend_vld_q || live_src >= pend_src_q)) begin
            pend_vld_d = 1'b1;
            pend_src_d = live_src;
            pend_pc_d  = live_pc[live_src];
          end
        end else begin
          stall      = 1'b0;
          pend_vld_d = 1'b0;
          if (|cand_v) begin
            grant    = 4'd1 << cand_src;
            redir_pc = cand_pc[cand_src];
            // Every stage younger than the winner gets killed.
            flush    = 3'((4'd1 << cand_src) - 4'd1);
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= 8'd0;
      pend_vld_q <= 1'b0;
      pend_src_q <= 2'd0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_src_q <= pend_src_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign o_pcIf0_RedirectArb_valid = grant[0];
  assign o_pcIf1_RedirectArb_valid = grant[1];
  assign o_pcIf2_RedirectArb_valid = grant[2];
  assign o_pcExu_RedirectArb_valid = grant[3];
  assign o_redir_pc  = redir_pc;
  assign o_stall     = stall;
  assign o_flush_if0 = flush[0];
  assign o_flush_if1 = flush[1];
  assign o_flush_if2 = flush[2];
  assign o_busy      = (state_q != ST_RUN) || pend_vld_q;

`ifdef REDIRECT_PERF_EN
  logic [31:0] perf_exu_q, perf_fe_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_exu_q <= 32'd0;
      perf_fe_q  <= 32'd0;
    end else begin
      if (grant[3])   perf_exu_q <= perf_exu_q + 32'd1;
      if (|grant[2:0]) perf_fe_q <= perf_fe_q + 32'd1;
    end
  end

  assign o_perf_exu_cnt = perf_exu_q;
  assign o_perf_fe_cnt  = perf_fe_q;
`else
  assign o_perf_exu_cnt = 32'd0;
  assign o_perf_fe_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_ifu_redirect_ctrl.sv
// Directed scoreboard bench for ifu_redirect_ctrl; honours REDIRECT_PERF_EN when checking counters.
module tb_ifu_redirect_ctrl;

  localparam int MXLEN = 64;

  logic             clk, rst, stall_in;
  logic             v0, v1, v2, v3;
  logic [MXLEN-1:0] p0, p1, p2, p3;
  logic             g0, g1, g2, g3, st_o, f0, f1, f2, busy;
  logic [MXLEN-1:0] rpc;
  logic [31:0]      pexu, pfe;

  ifu_redirect_ctrl #(.MXLEN(MXLEN), .BOOT_WAIT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall_in),
    .i_if0_redir_valid(v0), .i_if1_redir_valid(v1),
    .i_if2_redir_valid(v2), .i_exu_redir_valid(v3),
    .i_if0_redir_pc(p0), .i_if1_redir_pc(p1),
    .i_if2_redir_pc(p2), .i_exu_redir_pc(p3),
    .o_pcIf0_RedirectArb_valid(g0), .o_pcIf1_RedirectArb_valid(g1),
    .o_pcIf2_RedirectArb_valid(g2), .o_pcExu_RedirectArb_valid(g3),
    .o_redir_pc(rpc), .o_stall(st_o),
    .o_flush_if0(f0), .o_flush_if1(f1), .o_flush_if2(f2),
    .o_busy(busy), .o_perf_exu_cnt(pexu), .o_perf_fe_cnt(pfe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  g;
    logic [63:0] pc;
    logic [2:0]  f;
    logic        s;
    logic        b;
    logic [31:0] pe;
    logic [31:0] pf;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int step_n     = 0;
  int n_exu      = 0;
  int n_fe       = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL step%0d %s: observed %0h expected %0h", step_n, tag, obs, expv);
    end
  endtask

  // One clock: drive after the edge, queue the expectation, compare at the falling edge.
  task automatic cyc(input logic r, input logic [3:0] v, input logic s,
                     input logic [63:0] a0, input logic [63:0] a1,
                     input logic [63:0] a2, input logic [63:0] a3,
                     input logic [3:0] eg, input logic [63:0] epc, input logic [2:0] ef,
                     input logic es, input logic eb);
    exp_t e, o;
    @(posedge clk);
    #1;
    rst = r; {v3, v2, v1, v0} = v; stall_in = s;
    p0 = a0; p1 = a1; p2 = a2; p3 = a3;
    if (r) begin
      n_exu = 0;
      n_fe  = 0;
    end
    e.g = eg; e.pc = epc; e.f = ef; e.s = es; e.b = eb;
`ifdef REDIRECT_PERF_EN
    e.pe = 32'(n_exu); e.pf = 32'(n_fe);
`else
    e.pe = 32'd0; e.pf = 32'd0;
`endif
    sb.push_back(e);
    if (!r) begin
      if (eg[3]) n_exu++;
      if (|eg[2:0]) n_fe++;
    end
    @(negedge clk);
    step_n++;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      o = sb.pop_front();
      chk("grant",    {60'd0, g3, g2, g1, g0}, {60'd0, o.g});
      chk("redir_pc", rpc, o.pc);
      chk("flush",    {61'd0, f2, f1, f0}, {61'd0, o.f});
      chk("stall",    {63'd0, st_o}, {63'd0, o.s});
      chk("busy",     {63'd0, busy}, {63'd0, o.b});
      chk("perf_exu", {32'd0, pexu}, {32'd0, o.pe});
      chk("perf_fe",  {32'd0, pfe}, {32'd0, o.pf});
    end
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0;
    {v3, v2, v1, v0} = 4'b0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0;

    // Held in reset: requests ignored, outputs parked.
    cyc(1, 4'b1000, 0, 0, 0, 0, 'h9000, 4'b0, 0, 3'b0, 1, 1);
    cyc(1, 4'b0001, 1, 'h10, 0, 0, 0,   4'b0, 0, 3'b0, 1, 1);

    // Boot wait: exactly four stalled cycles, then RUN.
    repeat (4) cyc(0, 4'b0, 0, 0, 0, 0, 0, 4'b0, 0, 3'b0, 1, 1);
    cyc(0, 4'b0, 0, 0, 0, 0, 0, 4'b0, 0, 3'b0, 0, 0);

    // Three-way collision: exu wins and flushes everything.
    cyc(0, 4'b1101, 0, 'h1000, 0, 'h2000, 'h3000, 4'b1000, 'h3000, 3'b111, 0, 0);
    cyc(0, 4'b0, 0, 0, 0, 0, 0, 4'b0, 0, 3'b0, 0, 0);

    // Single sources and a two-way pick.
    cyc(0, 4'b0001, 0, 'h1100, 0, 0, 0, 4'b0001, 'h1100, 3'b000, 0, 0);
    cyc(0, 4'b0010, 0, 0, 'h1200, 0, 0, 4'b0010, 'h1200, 3'b001, 0, 0);
    cyc(0, 4'b0011, 0, 'h1300, 'h1400, 0, 0, 4'b0010, 'h1400, 3'b001, 0, 0);
    cyc(0, 4'b1000, 0, 0, 0, 0, 'h1500, 4'b1000, 'h1500, 3'b111, 0, 0);

    // Stall: if1 latched, then overwritten by if2; if2 replays on release.
    cyc(0, 4'b0010, 1, 0, 'h4000, 0, 0, 4'b0, 0, 3'b0, 1, 0);
    cyc(0, 4'b0100, 1, 0, 0, 'h5000, 0, 4'b0, 0, 3'b0, 1, 1);
    cyc(0, 4'b0000, 1, 0, 0, 0, 0,      4'b0, 0, 3'b0, 1, 1);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0,      4'b0100, 'h5000, 3'b011, 0, 1);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0,      4'b0, 0, 3'b0, 0, 0);

    // Pending exu survives a lower if0 and beats live if2 on release.
    cyc(0, 4'b1000, 1, 0, 0, 0, 'h6000, 4'b0, 0, 3'b0, 1, 0);
    cyc(0, 4'b0001, 1, 'h8000, 0, 0, 0, 4'b0, 0, 3'b0, 1, 1);
    cyc(0, 4'b0100, 0, 0, 0, 'h7000, 0, 4'b1000, 'h6000, 3'b111, 0, 1);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0,      4'b0, 0, 3'b0, 0, 0);

    // Same source pending vs live: live target wins.
    cyc(0, 4'b0010, 1, 0, 'hA000, 0, 0, 4'b0, 0, 3'b0, 1, 0);
    cyc(0, 4'b0010, 0, 0, 'hB000, 0, 0, 4'b0010, 'hB000, 3'b001, 0, 1);
    // Pending if2 beats live if1.
    cyc(0, 4'b0100, 1, 0, 0, 'hC000, 0, 4'b0, 0, 3'b0, 1, 0);
    cyc(0, 4'b0010, 0, 0, 'hD000, 0, 0, 4'b0100, 'hC000, 3'b011, 0, 1);
    // Equal priority overwrites pending.
    cyc(0, 4'b0010, 1, 0, 'hE000, 0, 0, 4'b0, 0, 3'b0, 1, 0);
    cyc(0, 4'b0010, 1, 0, 'hE100, 0, 0, 4'b0, 0, 3'b0, 1, 1);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0,      4'b0010, 'hE100, 3'b001, 0, 1);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0,      4'b0, 0, 3'b0, 0, 0);

    // Reset mid-stall with pending exu: immediate effect, then clean reboot.
    cyc(0, 4'b1000, 1, 0, 0, 0, 'hF000, 4'b0, 0, 3'b0, 1, 0);
    cyc(1, 4'b1000, 0, 0, 0, 0, 'hF000, 4'b0, 0, 3'b0, 1, 1);
    repeat (4) cyc(0, 4'b1000, 0, 0, 0, 0, 'hF100, 4'b0, 0, 3'b0, 1, 1);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0, 0, 3'b0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0, 0, 3'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
